// File: rtl/otter_lsu.sv
// otter_lsu: load/store unit between the OTTER core and a single-port data memory.
// Accepts one request at a time, checks alignment, drives byte-lane strobes and
// returns aligned, extended load data with a one-cycle response pulse.
// Optional feature macro: OTTER_LSU_RANGE_CHECK_EN (adds an address >= MEM_SIZE fault).
module otter_lsu #(
  parameter int unsigned MEM_SIZE = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_w_data,
  output logic        o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_r_data,
  output logic        o_dmem_re,
  output logic        o_dmem_we,
  output logic [3:0]  o_dmem_sel,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_w_data,
  input  logic [31:0] i_dmem_r_data
);

  // A memory size that is not a power of two is a configuration error.
  if (MEM_SIZE == 0 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_mem_size_check
    $error("otter_lsu: MEM_SIZE must be a power of two");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_DATA = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] w_data_q;
  logic        fault_q;
  logic [31:0] r_data_q;

  logic        req_fault;
  logic        accept;
  logic [3:0]  lane_sel;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign accept = (state == IDLE) && i_req_valid;

  // Decide at acceptance time whether the incoming request can be issued at all.
  always_comb begin
    req_fault = 1'b0;
    case (i_req_size)
      2'd1:    req_fault = i_req_addr[0];
      2'd2:    req_fault = |i_req_addr[1:0];
      2'd3:    req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
`ifdef OTTER_LSU_RANGE_CHECK_EN
    if ({1'b0, i_req_addr} >= 33'(MEM_SIZE)) req_fault = 1'b1;
`endif
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Latch the request on acceptance and capture load data on the RD_DATA exit edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= 32'd0;
      w_data_q   <= 32'd0;
      fault_q    <= 1'b0;
      r_data_q   <= 32'd0;
    end else if (accept) begin
      we_q       <= i_req_we;
      size_q     <= i_req_size;
      unsigned_q <= i_req_unsigned;
      addr_q     <= i_req_addr;
      w_data_q   <= i_req_w_data;
      fault_q    <= req_fault;
      r_data_q   <= 32'd0;
    end else if (state == RD_DATA) begin
      r_data_q   <= load_ext;
    end
  end

  // Byte-lane enables for the latched access size and offset.
  always_comb begin
    lane_sel = 4'b0000;
    case (size_q)
      2'd0:    lane_sel = 4'b0001 << addr_q[1:0];
      2'd1:    lane_sel = addr_q[1] ? 4'b1100 : 4'b0011;
      2'd2:    lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
  end

  // Replicate store data across lanes so the selected lanes always carry it.
  always_comb begin
    o_dmem_w_data = w_data_q;
    case (size_q)
      2'd0:    o_dmem_w_data = {4{w_data_q[7:0]}};
      2'd1:    o_dmem_w_data = {2{w_data_q[15:0]}};
      default: o_dmem_w_data = w_data_q;
    endcase
  end

  // Right-align the memory word by the byte offset, then truncate and extend.
  always_comb begin
    shifted  = i_dmem_r_data >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = unsigned_q ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign o_dmem_addr = addr_q;

  // Next-state sequencing and the per-state strobes and response outputs.
  always_comb begin
    state_next   = state;
    o_req_ready  = 1'b0;
    o_dmem_re    = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_sel   = 4'b0000;
    o_rsp_valid  = 1'b0;
    o_rsp_err    = 1'b0;
    o_rsp_r_data = 32'd0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_next = req_fault ? RESP : ACCESS;
      end
      ACCESS: begin
        o_dmem_re  = ~we_q;
        o_dmem_we  = we_q;
        o_dmem_sel = lane_sel;
        state_next = we_q ? RESP : RD_DATA;
      end
      RD_DATA: begin
        state_next = RESP;
      end
      RESP: begin
        o_rsp_valid  = 1'b1;
        o_rsp_err    = fault_q;
        o_rsp_r_data = fault_q ? 32'd0 : r_data_q;
        state_next   = IDLE;
      end
    endcase
  end

endmodule

// File: doc/otter_lsu.md
OTTER_LSU -- requirements
Module: otter_lsu

Interface
REQ-001 Parameter: MEM_SIZE, 65536, byte size of the data memory; power of two.
REQ-002 i_clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req_valid  input  1  CPU request present.
REQ-005 o_req_ready  output  1  LSU can accept a request; high only in IDLE.
REQ-006 i_req_we  input  1  1 = store, 0 = load.
REQ-007 i_req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 i_req_unsigned  input  1  zero-extend load data when 1, sign-extend when 0.
REQ-009 i_req_addr  input  32  byte address.
REQ-010 i_req_w_data  input  32  store data, right-justified.
REQ-011 o_rsp_valid  output  1  one-cycle completion pulse.
REQ-012 o_rsp_err  output  1  access faulted; qualified by o_rsp_valid.
REQ-013 o_rsp_r_data  output  32  aligned, extended load data; 0 for stores and faults.
REQ-014 o_dmem_re, o_dmem_we  output  1 each  memory read and write strobes.
REQ-015 o_dmem_sel  output  4  byte lane enables.
REQ-016 o_dmem_addr  output  32  request address, passed unmodified.
REQ-017 o_dmem_w_data  output  32  lane-replicated store data.
REQ-018 i_dmem_r_data  input  32  memory read word; valid the cycle after o_dmem_re.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RD_DATA and RESP.
REQ-020 Acceptance SHALL occur on a rising edge with IDLE and i_req_valid=1; all request fields are latched at that edge.
REQ-021 Faulted request: IDLE->RESP; no dmem strobe is ever asserted.
REQ-022 Store: IDLE->ACCESS->RESP; o_dmem_we=1 for exactly the one ACCESS cycle; o_rsp_valid high 2 cycles after acceptance.
REQ-023 Load: IDLE->ACCESS->RD_DATA->RESP; o_dmem_re=1 for exactly the one ACCESS cycle; i_dmem_r_data is sampled at the RD_DATA->RESP edge; o_rsp_valid high 3 cycles after acceptance.
REQ-024 RESP SHALL last one cycle, then return to IDLE; o_rsp_valid=1 only in RESP.
REQ-025 Fault conditions: size=3; half with addr[0]=1; word with addr[1:0]!=0. On fault, o_rsp_err=1 and o_rsp_r_data=0.
REQ-026 o_dmem_sel SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011 if addr[1]=0, else 4'b1100; word 4'b1111. Sel is driven during both loads and stores.
REQ-027 o_dmem_w_data SHALL be: byte {4{w_data[7:0]}}; half {2{w_data[15:0]}}; word w_data.
REQ-028 Load data SHALL be i_dmem_r_data shifted right by 8*addr[1:0], truncated to the access size, then zero- or sign-extended to 32 bits.
REQ-029 o_dmem_re, o_dmem_we and o_dmem_sel SHALL be 0 outside ACCESS.
REQ-030 i_req_valid outside IDLE SHALL be ignored; requests are never queued.

Reset
REQ-031 When i_rst_n=0, the FSM SHALL enter IDLE immediately, regardless of clock.
REQ-032 During reset: o_req_ready=1 (IDLE), and all other outputs and latched registers are 0.
REQ-033 Reset mid-transaction SHALL abort it: no o_rsp_valid pulse, and strobes drop immediately.

Configuration
REQ-034 Macro OTTER_LSU_RANGE_CHECK_EN.
  - Defined: i_req_addr >= MEM_SIZE is an additional fault condition under REQ-021/REQ-025.
  - Undefined: out-of-range addresses are issued to memory unchanged, and o_rsp_err reflects only the REQ-025 conditions.

Verification
REQ-035 Store word 0xDEADBEEF @0x10 -> o_dmem_we one cycle, sel=1111, w_data=0xDEADBEEF; rsp_valid 2 cycles after accept, err=0.
REQ-036 Store byte 0xA5 @0x13 -> sel=1000, w_data=0xA5A5A5A5. Then load byte signed @0x13 -> r_data=0xFFFFFFA5 at 3-cycle latency; unsigned load -> 0x000000A5.
REQ-037 Load half signed @0x22 with memory word 0x80017FFF -> sel=1100, r_data=0xFFFF8001.
REQ-038 Load word @0x6, and separately size=3 -> rsp_valid one cycle after accept, err=1, r_data=0, no re/we pulse.
REQ-039 Assert i_rst_n=0 mid-clock while in RD_DATA -> IDLE immediately, re=0, no rsp_valid. With OTTER_LSU_RANGE_CHECK_EN defined, store @0x10000 -> err=1, no we pulse.
